bt_cmd_rx: RTL and testbench
============================

BT_CMD_RX -- requirements
Module: bt_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_50M cycles per UART bit (115200 baud at 50 MHz).
REQ-002 SHALL have port clk_50M  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  UART serial line from the Bluetooth module; 8N1, LSB first, idle high.
REQ-005 SHALL have port byte_valid  output  1  one-cycle pulse when a byte with a good stop bit is received.
REQ-006 SHALL have port rx_byte  output  8  last good byte; held until the next byte_valid.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port cmd_valid  output  1  one-cycle pulse when a well-formed command frame completes.
REQ-009 SHALL have port cmd_id  output  8  ASCII command letter of the last valid frame.
REQ-010 SHALL have port cmd_arg  output  10  decimal argument of the last valid frame, 0-999.
REQ-011 SHALL have port cmd_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-013 SHALL run a receiver FSM with states IDLE, START, DATA, STOP.
REQ-014 IDLE: synchronized rx low -> START, bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, rx low -> DATA; rx high -> IDLE as a glitch, with no pulse.
REQ-016 DATA: SHALL sample 8 bits, each CLKS_PER_BIT cycles apart at bit centre, shifting LSB first, then go to STOP.
REQ-017 STOP: at stop-bit centre, rx high -> byte_valid pulse, rx_byte updated in the same cycle, then IDLE.
REQ-018 STOP: at stop-bit centre, rx low -> frame_err pulse, rx_byte unchanged, then wait for rx high before IDLE.
REQ-019 SHALL run a parser FSM with states P_IDLE, P_ID, P_ARG, advanced only on byte_valid.
REQ-020 Frame format: '$' (0x24), one letter 'A'-'Z', 1-3 decimal digits, '#' (0x23).
REQ-021 P_IDLE: '$' -> P_ID; any other byte is ignored silently.
REQ-022 P_ID: letter -> latched internally, argument accumulator cleared, digit count 0, then P_ARG; any other byte -> cmd_err, P_IDLE.
REQ-023 P_ARG: digit with count < 3 -> accumulator = accumulator*10 + digit, 10-bit, no overflow possible.
REQ-024 P_ARG: a fourth digit or a non-digit other than '#' or '$' -> cmd_err, P_IDLE.
REQ-025 P_ARG: '#' with count >= 1 -> cmd_valid one cycle after that byte_valid, cmd_id/cmd_arg updated in the same cycle, then P_IDLE.
REQ-026 P_ARG: '#' with count 0 -> cmd_err, P_IDLE.
REQ-027 '$' received in P_ID or P_ARG SHALL restart the frame (-> P_ID) with cmd_err pulsed once.
REQ-028 frame_err while the parser is in P_ID or P_ARG SHALL pulse cmd_err and return the parser to P_IDLE.
REQ-029 cmd_valid and cmd_err SHALL never assert in the same cycle.

Reset
REQ-030 On rst_n low: both synchronizer flops = 1, both FSMs in idle, all counters 0.
REQ-031 On rst_n low: all outputs 0, including rx_byte, cmd_id and cmd_arg.
REQ-032 Reset mid-byte or mid-frame SHALL discard partial data without any pulse after release.

Configuration
REQ-033 Macro RX_MAJORITY_EN defined: each data and stop bit SHALL be the 2-of-3 majority of samples at centre-1, centre and centre+1 cycles.
REQ-034 RX_MAJORITY_EN undefined: single sample at centre; timing of all pulses is otherwise identical.

Verification
REQ-035 Send "$F12#" at 434 clk/bit -> five byte_valid pulses; one cmd_valid with cmd_id=0x46, cmd_arg=12; no cmd_err.
REQ-036 Send "$M999#" then "$C7#" -> cmd_arg=999 (cmd_id 0x4D), then cmd_arg=7 (cmd_id 0x43); values held between pulses.
REQ-037 Send 0x41 with stop bit forced low -> frame_err one pulse, no byte_valid, rx_byte unchanged; next byte 0x55 received correctly.
REQ-038 Send "$S1234#" -> cmd_err on the fourth digit, no cmd_valid; send "$S#" -> cmd_err on '#'.
REQ-039 rx low pulse of 100 cycles while idle -> no byte_valid and no frame_err; with RX_MAJORITY_EN, a 1-cycle glitch at a data-bit centre does not corrupt the byte.
REQ-040 Assert rst_n low during the digits of "$F12#", release, send "$A5#" -> only cmd_valid with cmd_id=0x41, cmd_arg=5.

Source files
------------

// File: rtl/bt_cmd_rx.sv
// UART 8N1 receiver plus "$<letter><1-3 digits>#" command parser for a Bluetooth serial link.
// Define RX_MAJORITY_EN to take each data/stop bit as the 2-of-3 vote around bit centre.
module bt_cmd_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic [7:0] cmd_id,
    output logic [9:0] cmd_arg,
    output logic       cmd_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ID, P_ARG} p_state_t;

    logic             rx_meta, rx_sync, rx_d1;
    logic             rx_bit;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             stop_wait;
    logic             half_tick, bit_tick;
    logic             sample_data, stop_good, stop_bad;

    // Bit decisions use the sample one cycle old so that the majority window
    // (older, centre, newer) and the single-sample build share the same timing.
`ifdef RX_MAJORITY_EN
    logic rx_d2;
    assign rx_bit = (rx_d2 & rx_d1) | (rx_d2 & rx_sync) | (rx_d1 & rx_sync);
`else
    assign rx_bit = rx_d1;
`endif

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_d1   <= 1'b1;
`ifdef RX_MAJORITY_EN
            rx_d2   <= 1'b1;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_d1   <= rx_sync;
`ifdef RX_MAJORITY_EN
            rx_d2   <= rx_d1;
`endif
        end
    end

    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == BIT_LAST);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (!rx_sync) rx_next = START;
            START: if (half_tick) rx_next = rx_sync ? IDLE : DATA;
            DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = STOP;
            STOP: begin
                if (stop_wait) begin
                    if (rx_sync) rx_next = IDLE;
                end else if (bit_tick && rx_bit) begin
                    rx_next = IDLE;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        sample_data = (rx_state == DATA) && bit_tick;
        stop_good   = (rx_state == STOP) && !stop_wait && bit_tick && rx_bit;
        stop_bad    = (rx_state == STOP) && !stop_wait && bit_tick && !rx_bit;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            stop_wait  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= '0;
        end else begin
            byte_valid <= stop_good;
            frame_err  <= stop_bad;
            if (stop_good) rx_byte <= shreg;
            if (sample_data) shreg <= {rx_bit, shreg[7:1]};
            if (rx_state == IDLE || rx_state != rx_next || bit_tick) clk_cnt <= '0;
            else                                                      clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == IDLE)  bit_cnt <= '0;
            else if (sample_data)  bit_cnt <= bit_cnt + 3'd1;
            if (stop_bad)                stop_wait <= 1'b1;
            else if (rx_state != STOP)   stop_wait <= 1'b0;
        end
    end

    p_state_t   p_state, p_next;
    logic [7:0] id_latch;
    logic [9:0] acc, acc_next;
    logic [1:0] dig_cnt;
    logic       is_dollar, is_hash, is_letter, is_digit;
    logic       p_done, p_err, p_latch, p_acc;

    assign is_dollar = (rx_byte == 8'h24);
    assign is_hash   = (rx_byte == 8'h23);
    assign is_letter = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
    assign is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign acc_next  = (acc << 3) + (acc << 1) + {6'd0, rx_byte[3:0]};

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) p_state <= P_IDLE;
        else        p_state <= p_next;
    end

    // A framing error mid-command abandons the frame; byte_valid and frame_err are exclusive.
    always_comb begin
        p_next = p_state;
        if (frame_err) begin
            p_next = P_IDLE;
        end else if (byte_valid) begin
            case (p_state)
                P_IDLE:  if (is_dollar) p_next = P_ID;
                P_ID:    p_next = is_dollar ? P_ID : (is_letter ? P_ARG : P_IDLE);
                P_ARG:   p_next = is_dollar ? P_ID :
                                  ((is_digit && dig_cnt != 2'd3) ? P_ARG : P_IDLE);
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        p_done  = 1'b0;
        p_err   = 1'b0;
        p_latch = 1'b0;
        p_acc   = 1'b0;
        if (frame_err) begin
            p_err = (p_state != P_IDLE);
        end else if (byte_valid) begin
            case (p_state)
                P_ID: begin
                    if (is_letter) p_latch = 1'b1;
                    else           p_err   = 1'b1;
                end
                P_ARG: begin
                    if (is_digit && dig_cnt != 2'd3)   p_acc  = 1'b1;
                    else if (is_hash && dig_cnt != 0)  p_done = 1'b1;
                    else                               p_err  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            id_latch  <= '0;
            acc       <= '0;
            dig_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_id    <= '0;
            cmd_arg   <= '0;
        end else begin
            cmd_valid <= p_done;
            cmd_err   <= p_err;
            if (p_done) begin
                cmd_id  <= id_latch;
                cmd_arg <= acc;
            end
            if (p_latch) begin
                id_latch <= rx_byte;
                acc      <= '0;
                dig_cnt  <= '0;
            end else if (p_acc) begin
                acc      <= acc_next;
                dig_cnt  <= dig_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx: UART bytes and command frames driven on rx, pulses counted on the falling edge.
module tb_bt_cmd_rx;

    // Bit period kept shorter than 434 to bound run length; half a bit still exceeds the 100-cycle glitch.
    localparam int CPB = 210;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       byte_valid, frame_err, cmd_valid, cmd_err;
    logic [7:0] rx_byte, cmd_id;
    logic [9:0] cmd_arg;

    int n_vec  = 0;
    int n_miss = 0;
    int n_bv = 0, n_fe = 0, n_cv = 0, n_ce = 0, n_both = 0;

    always #10 clk_50M = ~clk_50M;

    bt_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .cmd_arg   (cmd_arg),
        .cmd_err   (cmd_err)
    );

    always @(negedge clk_50M) begin
        if (byte_valid) n_bv++;
        if (frame_err)  n_fe++;
        if (cmd_valid)  n_cv++;
        if (cmd_err)    n_ce++;
        if (cmd_valid && cmd_err) n_both++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        if (!stop) idle(CPB);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        idle(4);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(5);
        n_vec++;
        if ({byte_valid, frame_err, cmd_valid, cmd_err} !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_pulses: got %b expected 0000", {byte_valid, frame_err, cmd_valid, cmd_err});
        end
        n_vec++;
        if (rx_byte !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_rx_byte: got %h expected 00", rx_byte);
        end
        n_vec++;
        if ({cmd_id, cmd_arg} !== 18'd0) begin
            n_miss++;
            $display("FAIL reset_cmd: got id %h arg %0d expected 00/0", cmd_id, cmd_arg);
        end
        rst_n = 1'b1;
        idle(20);
        n_vec++;
        if (n_bv + n_fe + n_cv + n_ce !== 0) begin
            n_miss++;
            $display("FAIL reset_quiet: got %0d pulses expected 0", n_bv + n_fe + n_cv + n_ce);
        end
    endtask

    task automatic test_single_cmd;
        int b0, c0, e0;
        b0 = n_bv; c0 = n_cv; e0 = n_ce;
        send_str("$F12#");
        n_vec++;
        if (n_bv - b0 !== 5) begin
            n_miss++;
            $display("FAIL f12_byte_count: got %0d expected 5", n_bv - b0);
        end
        n_vec++;
        if (n_cv - c0 !== 1) begin
            n_miss++;
            $display("FAIL f12_cmd_valid_count: got %0d expected 1", n_cv - c0);
        end
        n_vec++;
        if (n_ce - e0 !== 0) begin
            n_miss++;
            $display("FAIL f12_cmd_err_count: got %0d expected 0", n_ce - e0);
        end
        n_vec++;
        if (cmd_id !== 8'h46 || cmd_arg !== 10'd12) begin
            n_miss++;
            $display("FAIL f12_cmd: got id %h arg %0d expected 46/12", cmd_id, cmd_arg);
        end
        n_vec++;
        if (rx_byte !== 8'h23) begin
            n_miss++;
            $display("FAIL f12_last_byte: got %h expected 23", rx_byte);
        end
    endtask

    task automatic test_back_to_back;
        int c0, e0;
        c0 = n_cv; e0 = n_ce;
        send_str("$M999#");
        n_vec++;
        if (n_cv - c0 !== 1 || cmd_id !== 8'h4D || cmd_arg !== 10'd999) begin
            n_miss++;
            $display("FAIL m999_cmd: got n %0d id %h arg %0d expected 1/4D/999", n_cv - c0, cmd_id, cmd_arg);
        end
        send_str("$C7");
        n_vec++;
        if (cmd_id !== 8'h4D || cmd_arg !== 10'd999) begin
            n_miss++;
            $display("FAIL m999_held: got id %h arg %0d expected 4D/999", cmd_id, cmd_arg);
        end
        send_str("#");
        n_vec++;
        if (n_cv - c0 !== 2 || cmd_id !== 8'h43 || cmd_arg !== 10'd7) begin
            n_miss++;
            $display("FAIL c7_cmd: got n %0d id %h arg %0d expected 2/43/7", n_cv - c0, cmd_id, cmd_arg);
        end
        n_vec++;
        if (n_ce - e0 !== 0) begin
            n_miss++;
            $display("FAIL b2b_cmd_err: got %0d expected 0", n_ce - e0);
        end
    endtask

    task automatic test_frame_err;
        int b0, f0, c0, e0;
        b0 = n_bv; f0 = n_fe; e0 = n_ce;
        send_byte(8'h41, 1'b0);
        n_vec++;
        if (n_fe - f0 !== 1 || n_bv - b0 !== 0) begin
            n_miss++;
            $display("FAIL ferr_pulses: got fe %0d bv %0d expected 1/0", n_fe - f0, n_bv - b0);
        end
        n_vec++;
        if (rx_byte !== 8'h23) begin
            n_miss++;
            $display("FAIL ferr_rx_byte_held: got %h expected 23", rx_byte);
        end
        send_byte(8'h55, 1'b1);
        n_vec++;
        if (n_bv - b0 !== 1 || rx_byte !== 8'h55 || n_fe - f0 !== 1) begin
            n_miss++;
            $display("FAIL ferr_recover: got bv %0d byte %h fe %0d expected 1/55/1", n_bv - b0, rx_byte, n_fe - f0);
        end
        n_vec++;
        if (n_ce - e0 !== 0) begin
            n_miss++;
            $display("FAIL ferr_idle_cmd_err: got %0d expected 0", n_ce - e0);
        end
        send_str("$B");
        c0 = n_cv; e0 = n_ce;
        send_byte(8'h31, 1'b0);
        idle(4);
        n_vec++;
        if (n_ce - e0 !== 1 || n_cv - c0 !== 0) begin
            n_miss++;
            $display("FAIL ferr_in_frame: got ce %0d cv %0d expected 1/0", n_ce - e0, n_cv - c0);
        end
    endtask

    task automatic test_cmd_errors;
        int c0, e0;
        c0 = n_cv; e0 = n_ce;
        send_str("$S123");
        n_vec++;
        if (n_ce - e0 !== 0) begin
            n_miss++;
            $display("FAIL s123_no_err: got %0d expected 0", n_ce - e0);
        end
        send_str("4");
        n_vec++;
        if (n_ce - e0 !== 1 || n_cv - c0 !== 0) begin
            n_miss++;
            $display("FAIL s1234_err: got ce %0d cv %0d expected 1/0", n_ce - e0, n_cv - c0);
        end
        c0 = n_cv; e0 = n_ce;
        send_str("$S#");
        n_vec++;
        if (n_ce - e0 !== 1 || n_cv - c0 !== 0) begin
            n_miss++;
            $display("FAIL s_empty_err: got ce %0d cv %0d expected 1/0", n_ce - e0, n_cv - c0);
        end
        n_vec++;
        if (cmd_id !== 8'h43 || cmd_arg !== 10'd7) begin
            n_miss++;
            $display("FAIL err_cmd_held: got id %h arg %0d expected 43/7", cmd_id, cmd_arg);
        end
    endtask

    task automatic test_glitch;
        int b0, f0;
        b0 = n_bv; f0 = n_fe;
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(3 * CPB);
        n_vec++;
        if (n_bv - b0 !== 0 || n_fe - f0 !== 0) begin
            n_miss++;
            $display("FAIL idle_glitch: got bv %0d fe %0d expected 0/0", n_bv - b0, n_fe - f0);
        end
`ifdef RX_MAJORITY_EN
        b0 = n_bv;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = i[0];
            if (i == 3) begin
                idle(CPB / 2);
                rx = ~rx;
                idle(1);
                rx = ~rx;
                idle(CPB - CPB / 2 - 1);
            end else begin
                idle(CPB);
            end
        end
        rx = 1'b1;
        idle(2 * CPB);
        n_vec++;
        if (n_bv - b0 !== 1 || rx_byte !== 8'hAA) begin
            n_miss++;
            $display("FAIL majority_glitch: got bv %0d byte %h expected 1/AA", n_bv - b0, rx_byte);
        end
`endif
    endtask

    task automatic test_reset_mid_frame;
        int b0, f0, c0, e0;
        send_str("$F1");
        rx = 1'b0;
        idle(3 * CPB);
        b0 = n_bv; f0 = n_fe; c0 = n_cv; e0 = n_ce;
        rst_n = 1'b0;
        idle(5);
        n_vec++;
        if (rx_byte !== 8'h00 || cmd_id !== 8'h00 || cmd_arg !== 10'd0) begin
            n_miss++;
            $display("FAIL midrst_clear: got byte %h id %h arg %0d expected 00/00/0", rx_byte, cmd_id, cmd_arg);
        end
        rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(3 * CPB);
        n_vec++;
        if (n_bv - b0 + n_fe - f0 + n_cv - c0 + n_ce - e0 !== 0) begin
            n_miss++;
            $display("FAIL midrst_quiet: got %0d pulses expected 0", n_bv - b0 + n_fe - f0 + n_cv - c0 + n_ce - e0);
        end
        send_str("$A5#");
        n_vec++;
        if (n_cv - c0 !== 1 || n_ce - e0 !== 0 || n_fe - f0 !== 0) begin
            n_miss++;
            $display("FAIL a5_counts: got cv %0d ce %0d fe %0d expected 1/0/0", n_cv - c0, n_ce - e0, n_fe - f0);
        end
        n_vec++;
        if (cmd_id !== 8'h41 || cmd_arg !== 10'd5) begin
            n_miss++;
            $display("FAIL a5_cmd: got id %h arg %0d expected 41/5", cmd_id, cmd_arg);
        end
    endtask

    initial begin
        test_reset;
        test_single_cmd;
        test_back_to_back;
        test_frame_err;
        test_cmd_errors;
        test_glitch;
        test_reset_mid_frame;
        n_vec++;
        if (n_both !== 0) begin
            n_miss++;
            $display("FAIL valid_err_overlap: got %0d cycles expected 0", n_both);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
